// File: rtl/binary_activation_sign_pack.sv
// Binarizes IN_SIZE signed elements per input beat against THRESHOLD and packs
// K = OUT_SIZE/IN_SIZE consecutive beats into one OUT_SIZE-wide binary vector.
module binary_activation_sign_pack #(
  parameter int                         IN_WIDTH  = 8,
  parameter int                         IN_SIZE   = 2,
  parameter int                         OUT_SIZE  = 4,
  parameter logic signed [IN_WIDTH-1:0] THRESHOLD = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] data_in [IN_SIZE],
  input  logic                data_in_valid,
  output logic                data_in_ready,
  output logic [0:0]          data_out [OUT_SIZE],
  output logic                data_out_valid,
  input  logic                data_out_ready
);

  localparam int K = OUT_SIZE / IN_SIZE;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

  generate
    if (((OUT_SIZE % IN_SIZE) != 0) || (OUT_SIZE < IN_SIZE)) begin : g_bad_cfg
      $error("binary_activation_sign_pack: OUT_SIZE must be a multiple of IN_SIZE and >= IN_SIZE");
    end
  endgenerate

  logic [IN_SIZE-1:0]  bin_s;
  logic [OUT_SIZE-1:0] vec_s;
  logic [OUT_SIZE-1:0] out_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                valid_r;
  logic                last_s;
  logic                in_fire_s;

  assign last_s         = (cnt_r == CNT_LAST);
  // Only the closing beat of a group can be held off, and only by a stalled output.
  assign data_in_ready  = !last_s || !valid_r || data_out_ready;
  assign in_fire_s      = data_in_valid && data_in_ready;
  assign data_out_valid = valid_r;

  // Full-width signed compare of every element against the threshold.
  always_comb begin
    bin_s = {IN_SIZE{1'b0}};
    for (int e = 0; e < IN_SIZE; e++) begin
      bin_s[e] = ($signed(data_in[e]) >= THRESHOLD);
    end
  end

  // Fan the packed output register out to the unpacked output port.
  always_comb begin
    for (int i = 0; i < OUT_SIZE; i++) begin
      data_out[i] = out_r[i];
    end
  end

  generate
    if (K > 1) begin : g_gather
      logic [(K-1)*IN_SIZE-1:0] gather_r;

      // Park the bits of beats 0..K-2 until the closing beat arrives.
      always_ff @(posedge clk) begin
        if (!rst) begin
          gather_r <= {((K-1)*IN_SIZE){1'b0}};
        end else if (in_fire_s && !last_s) begin
          gather_r[int'(cnt_r)*IN_SIZE +: IN_SIZE] <= bin_s;
        end
      end

      assign vec_s = {bin_s, gather_r};
    end else begin : g_direct
      assign vec_s = bin_s;
    end
  endgenerate

  // Beat position within the current group.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (in_fire_s) begin
      cnt_r <= last_s ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
    end
  end

  // Output slot: a load on the closing beat takes priority over a drain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_r   <= {OUT_SIZE{1'b0}};
      valid_r <= 1'b0;
    end else if (in_fire_s && last_s) begin
      out_r   <= vec_s;
      valid_r <= 1'b1;
    end else if (valid_r && data_out_ready) begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_binary_activation_sign_pack.sv
// Bench: four instances (K=2 at thresholds 0, 3, -128 and K=1 at threshold 0)
// share one stimulus stream and are each tracked by a queue-based reference model.
module tb_binary_activation_sign_pack;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] din [2];

  logic       r0, r1, r2, r3;
  logic       v0, v1, v2, v3;
  logic [0:0] o0 [4];
  logic [0:0] o1 [4];
  logic [0:0] o2 [4];
  logic [0:0] o3 [2];
  logic [3:0] p0, p1, p2, p3;

  assign p0 = {o0[3], o0[2], o0[1], o0[0]};
  assign p1 = {o1[3], o1[2], o1[1], o1[0]};
  assign p2 = {o2[3], o2[2], o2[1], o2[0]};
  assign p3 = {2'b00, o3[1], o3[0]};

  always #5 clk = ~clk;

  binary_activation_sign_pack #(.IN_WIDTH(8), .IN_SIZE(2), .OUT_SIZE(4), .THRESHOLD(8'sd0)) dut0 (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(in_valid), .data_in_ready(r0),
    .data_out(o0), .data_out_valid(v0), .data_out_ready(out_ready));
  binary_activation_sign_pack #(.IN_WIDTH(8), .IN_SIZE(2), .OUT_SIZE(4), .THRESHOLD(8'sd3)) dut1 (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(in_valid), .data_in_ready(r1),
    .data_out(o1), .data_out_valid(v1), .data_out_ready(out_ready));
  binary_activation_sign_pack #(.IN_WIDTH(8), .IN_SIZE(2), .OUT_SIZE(4), .THRESHOLD(-8'sd128)) dut2 (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(in_valid), .data_in_ready(r2),
    .data_out(o2), .data_out_valid(v2), .data_out_ready(out_ready));
  binary_activation_sign_pack #(.IN_WIDTH(8), .IN_SIZE(2), .OUT_SIZE(2), .THRESHOLD(8'sd0)) dut3 (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(in_valid), .data_in_ready(r3),
    .data_out(o3), .data_out_valid(v3), .data_out_ready(out_ready));

  int checks   = 0;
  int failures = 0;

  // Reference model: completed vectors waiting for the consumer, plus the open group.
  logic [3:0] eq  [4][8];
  int         eh  [4];
  int         et  [4];
  logic [3:0] grp [4];
  int         gn  [4];
  int         acc0 = 0;

  typedef struct {
    logic [7:0] b0e0, b0e1, b1e0, b1e1;
    logic [3:0] e0, e1, e2;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic bin(input logic [7:0] x, input int thr);
    return ($signed(x) >= thr);
  endfunction

  function automatic logic [7:0] rnd_elem();
    if ($urandom_range(0, 1) == 0) return 8'($urandom);
    return 8'($urandom_range(0, 8)) - 8'd3;
  endfunction

  task automatic model_clear(input int d);
    eh[d] = 0; et[d] = 0; gn[d] = 0; grp[d] = 4'b0000;
  endtask

  // One clock: compare every instance with the model, advance the model, cross the edge.
  task automatic tick();
    logic       rd [4];
    logic       vl [4];
    logic [3:0] vc [4];
    int         kk, thr;
    logic       occ;
    #1;
    rd[0] = r0; rd[1] = r1; rd[2] = r2; rd[3] = r3;
    vl[0] = v0; vl[1] = v1; vl[2] = v2; vl[3] = v3;
    vc[0] = p0; vc[1] = p1; vc[2] = p2; vc[3] = p3;
    for (int d = 0; d < 4; d++) begin
      kk  = (d == 3) ? 1 : 2;
      thr = (d == 1) ? 3 : ((d == 2) ? -128 : 0);
      occ = (et[d] != eh[d]);
      chk($sformatf("valid_dut%0d", d), 32'(vl[d]), 32'(occ));
      if (occ) chk($sformatf("data_dut%0d", d), 32'(vc[d]), 32'(eq[d][eh[d] % 8]));
      chk($sformatf("ready_dut%0d", d), 32'(rd[d]), 32'(!((gn[d] == kk - 1) && occ && !out_ready)));
      if (!rst) begin
        model_clear(d);
      end else begin
        if (occ && out_ready) eh[d]++;
        if (in_valid && rd[d]) begin
          grp[d][gn[d]*2 +: 2] = {bin(din[1], thr), bin(din[0], thr)};
          gn[d]++;
          if (d == 0) acc0++;
          if (gn[d] == kk) begin
            eq[d][et[d] % 8] = grp[d];
            et[d]++;
            gn[d]  = 0;
            grp[d] = 4'b0000;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] k1a [8];
    logic [7:0] k1b [8];
    int         cyc;

    tbl[0] = '{8'h05, 8'hFD, 8'h00, 8'hFF, 4'b0101, 4'b0001, 4'b1111};
    tbl[1] = '{8'h03, 8'h02, 8'h7F, 8'h80, 4'b0111, 4'b0101, 4'b1111};
    tbl[2] = '{8'h80, 8'h80, 8'h80, 8'h80, 4'b0000, 4'b0000, 4'b1111};
    tbl[3] = '{8'h00, 8'hFF, 8'h7F, 8'h00, 4'b1101, 4'b0100, 4'b1111};

    for (int d = 0; d < 4; d++) model_clear(d);
    din[0] = 8'h00; din[1] = 8'h00;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(v0), 32'd0);
    chk("reset_data", 32'(p0), 32'd0);
    rst = 1'b1;
    #1;
    chk("ready_after_reset", 32'(r0), 32'd1);

    // Table vectors: two beats with the consumer always ready.
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      in_valid = 1'b1;
      din[0] = tbl[t].b0e0; din[1] = tbl[t].b0e1;
      tick();
      din[0] = tbl[t].b1e0; din[1] = tbl[t].b1e1;
      tick();
      chk($sformatf("tbl%0d_valid", t), 32'(v0), 32'd1);
      chk($sformatf("tbl%0d_thr0", t), 32'(p0), 32'(tbl[t].e0));
      chk($sformatf("tbl%0d_thr3", t), 32'(p1), 32'(tbl[t].e1));
      chk($sformatf("tbl%0d_thrmin", t), 32'(p2), 32'(tbl[t].e2));
      in_valid = 1'b0;
      tick();
      chk($sformatf("tbl%0d_valid_drop", t), 32'(v0), 32'd0);
    end

    // Backpressure: A held, B beat 0 accepted, B beat 1 waits, then both move together.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    din[0] = 8'h05; din[1] = 8'hFD; tick();
    din[0] = 8'h00; din[1] = 8'hFF; tick();
    chk("bp_a_valid", 32'(v0), 32'd1);
    din[0] = 8'hFF; din[1] = 8'h02; tick();
    din[0] = 8'hFB; din[1] = 8'h07;
    #1;
    chk("bp_b1_blocked", 32'(r0), 32'd0);
    tick();
    tick();
    chk("bp_a_held_valid", 32'(v0), 32'd1);
    chk("bp_a_held_data", 32'(p0), 32'b0101);
    out_ready = 1'b1;
    #1;
    chk("bp_b1_released", 32'(r0), 32'd1);
    tick();
    chk("bp_b_valid", 32'(v0), 32'd1);
    chk("bp_b_data", 32'(p0), 32'b1010);
    in_valid = 1'b0;
    tick();
    chk("bp_b_drop", 32'(v0), 32'd0);

    // Reset in the middle of a group discards the partial beat.
    in_valid = 1'b1;
    din[0] = 8'h09; din[1] = 8'h09; tick();
    rst = 1'b0; in_valid = 1'b0; tick();
    rst = 1'b1;
    chk("mid_reset_valid", 32'(v0), 32'd0);
    #1;
    chk("mid_reset_ready", 32'(r0), 32'd1);
    in_valid = 1'b1;
    din[0] = 8'hFF; din[1] = 8'hFF; tick();
    chk("mid_reset_no_early", 32'(v0), 32'd0);
    din[0] = 8'h01; din[1] = 8'h01; tick();
    chk("mid_reset_valid_new", 32'(v0), 32'd1);
    chk("mid_reset_data_new", 32'(p0), 32'b1100);
    in_valid = 1'b0;
    tick();

    // K=1 instance streaming one beat per cycle.
    for (int i = 0; i < 8; i++) begin
      k1a[i] = rnd_elem();
      k1b[i] = rnd_elem();
    end
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din[0] = k1a[i]; din[1] = k1b[i];
      tick();
      chk($sformatf("k1_valid%0d", i), 32'(v3), 32'd1);
      chk($sformatf("k1_data%0d", i), 32'(p3), 32'({bin(k1b[i], 0), bin(k1a[i], 0)}));
    end
    in_valid = 1'b0;
    tick();
    chk("k1_drop", 32'(v3), 32'd0);

    // Random valid/ready toggling; the model compares every cycle.
    acc0 = 0;
    cyc  = 0;
    while ((acc0 < 1000) && (cyc < 20000)) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      din[0] = rnd_elem();
      din[1] = rnd_elem();
      tick();
      cyc++;
    end
    chk("random_budget", 32'(acc0 >= 1000), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("drain_empty", 32'(v0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
